// File: rtl/led_fade_ctrl.sv
// Duty-cycle fader feeding pwm_led: ramps DutyCycle one LSB per interval toward a
// commanded target, or bounces 0<->target continuously in breathe mode.
module led_fade_ctrl #(
   parameter int RATE_W = 16
) (
   input  logic              SysClk,
   input  logic              Reset,
   input  logic              CmdValid,
   output logic              CmdReady,
   input  logic [7:0]        CmdTarget,
   input  logic [RATE_W-1:0] CmdRate,
   input  logic              CmdBreathe,
   output logic [7:0]        DutyCycle,
   output logic              Busy,
   output logic              Done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_UP,
      ST_DOWN
   } state_t;

   localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

   state_t            state_q,   state_d;
   logic [7:0]        target_q,  target_d;
   logic [RATE_W-1:0] rate_q,    rate_d;
   logic              breathe_q, breathe_d;
   logic [RATE_W-1:0] int_cnt_q, int_cnt_d;
   logic [7:0]        duty_q,    duty_d;
   logic              done_q,    done_d;
   logic              eq_pend_q, eq_pend_d;

   logic              cmd_accept;
   logic              cmd_breathe_eff;
   logic [7:0]        duty_up;
   logic [7:0]        duty_dn;

   assign CmdReady        = (state_q == ST_IDLE) || breathe_q;
   assign cmd_accept      = CmdValid && CmdReady;
   // A breathe toward 0 has no range to bounce over, so it degrades to a plain fade.
   assign cmd_breathe_eff = CmdBreathe && (CmdTarget != 8'd0);
   assign duty_up         = duty_q + 8'd1;
   assign duty_dn         = duty_q - 8'd1;

   assign DutyCycle = duty_q;
   assign Busy      = (state_q != ST_IDLE);
   assign Done      = done_q;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      rate_d    = rate_q;
      breathe_d = breathe_q;
      int_cnt_d = int_cnt_q;
      duty_d    = duty_q;
      done_d    = eq_pend_q;
      eq_pend_d = 1'b0;

      if (cmd_accept) begin
         target_d  = CmdTarget;
         rate_d    = (CmdRate == '0) ? RATE_ONE : CmdRate;
         breathe_d = cmd_breathe_eff;
         int_cnt_d = '0;
         if (duty_q < CmdTarget) begin
            state_d = ST_UP;
         end else if (duty_q > CmdTarget || cmd_breathe_eff) begin
            state_d = ST_DOWN;
         end else begin
            // Already at target: no ramp, but the requester still gets its Done.
            state_d   = ST_IDLE;
            eq_pend_d = 1'b1;
         end
      end else if (state_q != ST_IDLE) begin
         if (int_cnt_q == rate_q - RATE_ONE) begin
            int_cnt_d = '0;
            if (state_q == ST_UP) begin
               if (duty_q != 8'hFF) begin
                  duty_d = duty_up;
               end
               if (duty_up == target_q || duty_q == 8'hFF) begin
                  if (breathe_q) begin
                     state_d = ST_DOWN;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end else begin
               if (duty_q != 8'h00) begin
                  duty_d = duty_dn;
               end
               // Breathe descends all the way to 0 regardless of target.
               if (breathe_q) begin
                  if (duty_dn == 8'h00 || duty_q == 8'h00) begin
                     state_d = ST_UP;
                  end
               end else if (duty_dn == target_q || duty_q == 8'h00) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end else begin
            int_cnt_d = int_cnt_q + RATE_ONE;
         end
      end
   end

   always_ff @(posedge SysClk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         target_q  <= 8'd0;
         rate_q    <= RATE_ONE;
         breathe_q <= 1'b0;
         int_cnt_q <= '0;
         duty_q    <= 8'd0;
         done_q    <= 1'b0;
         eq_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         rate_q    <= rate_d;
         breathe_q <= breathe_d;
         int_cnt_q <= int_cnt_d;
         duty_q    <= duty_d;
         done_q    <= done_d;
         eq_pend_q <= eq_pend_d;
      end
   end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl: ramps, rate 0, equal target, breathe,
// busy rejection and mid-ramp reset, with hand-computed expectations.
module tb_led_fade_ctrl;

   logic        SysClk = 1'b0;
   logic        Reset;
   logic        CmdValid;
   logic        CmdReady;
   logic [7:0]  CmdTarget;
   logic [15:0] CmdRate;
   logic        CmdBreathe;
   logic [7:0]  DutyCycle;
   logic        Busy;
   logic        Done;

   int vectors     = 0;
   int miscompares = 0;
   int first_done;
   int n_done;
   int bexp [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

   led_fade_ctrl #(.RATE_W(16)) dut (
      .SysClk     (SysClk),
      .Reset      (Reset),
      .CmdValid   (CmdValid),
      .CmdReady   (CmdReady),
      .CmdTarget  (CmdTarget),
      .CmdRate    (CmdRate),
      .CmdBreathe (CmdBreathe),
      .DutyCycle  (DutyCycle),
      .Busy       (Busy),
      .Done       (Done)
   );

   always #5 SysClk = ~SysClk;

   task automatic tick();
      @(posedge SysClk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Presents one command for a single edge; returns just after the accept edge E0.
   task automatic run_cmd(input logic [7:0] t, input logic [15:0] r, input logic b);
      CmdValid   = 1'b1;
      CmdTarget  = t;
      CmdRate    = r;
      CmdBreathe = b;
      tick();
      CmdValid   = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int cyc;
      cyc = 0;
      while (Done !== 1'b1 && cyc < budget) begin
         tick();
         cyc++;
      end
      chk(tag, int'(Done), 1);
   endtask

   initial begin
      Reset      = 1'b1;
      CmdValid   = 1'b0;
      CmdTarget  = 8'd0;
      CmdRate    = 16'd0;
      CmdBreathe = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      chk("rst_duty", int'(DutyCycle), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_ready", int'(CmdReady), 1);

      // Basic ramp up: 0 -> 4 at rate 3
      run_cmd(8'd4, 16'd3, 1'b0);
      chk("up_e0_duty", int'(DutyCycle), 0);
      chk("up_e0_busy", int'(Busy), 1);
      chk("up_e0_ready", int'(CmdReady), 0);
      chk("up_e0_done", int'(Done), 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("up_duty_%0d", k), int'(DutyCycle), k / 3);
         chk($sformatf("up_done_%0d", k), int'(Done), (k == 12) ? 1 : 0);
         chk($sformatf("up_ready_%0d", k), int'(CmdReady), (k == 12) ? 1 : 0);
         chk($sformatf("up_busy_%0d", k), int'(Busy), (k == 12) ? 0 : 1);
      end

      // Move to 10, then rate 0 down to 7
      run_cmd(8'd10, 16'd1, 1'b0);
      wait_done(50, "to10_timeout");
      chk("to10_duty", int'(DutyCycle), 10);
      run_cmd(8'd7, 16'd0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("r0_duty_%0d", k), int'(DutyCycle), 10 - k);
         chk($sformatf("r0_done_%0d", k), int'(Done), (k == 3) ? 1 : 0);
      end

      // Equal target
      run_cmd(8'd7, 16'd1, 1'b0);
      chk("eq_e0_busy", int'(Busy), 0);
      chk("eq_e0_done", int'(Done), 0);
      tick();
      chk("eq_e1_done", int'(Done), 1);
      chk("eq_e1_busy", int'(Busy), 0);
      chk("eq_e1_duty", int'(DutyCycle), 7);
      tick();
      chk("eq_e2_done", int'(Done), 0);

      // Full span 7 -> 255: 248 steps, no wrap, one Done
      run_cmd(8'd255, 16'd1, 1'b0);
      first_done = 0;
      n_done     = 0;
      for (int k = 1; k <= 260; k++) begin
         tick();
         if (Done === 1'b1) begin
            n_done++;
            if (first_done == 0) first_done = k;
         end
      end
      chk("span_done_cycle", first_done, 248);
      chk("span_done_count", n_done, 1);
      chk("span_duty", int'(DutyCycle), 255);

      // Busy rejection: 255 -> 200 at rate 2 while a Target=0 command is held
      run_cmd(8'd200, 16'd2, 1'b0);
      CmdValid   = 1'b1;
      CmdTarget  = 8'd0;
      CmdRate    = 16'd1;
      first_done = 0;
      n_done     = 0;
      for (int k = 1; k <= 130; k++) begin
         tick();
         if (Done === 1'b1) begin
            n_done++;
            if (first_done == 0) begin
               first_done = k;
               CmdValid   = 1'b0;
            end
         end
      end
      CmdValid = 1'b0;
      chk("rej_done_cycle", first_done, 110);
      chk("rej_done_count", n_done, 1);
      chk("rej_duty", int'(DutyCycle), 200);
      chk("rej_busy", int'(Busy), 0);

      // Breathe 0 <-> 3 at rate 1, then non-breathe to 0 while rising at 2
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("br_start_duty", int'(DutyCycle), 0);
      run_cmd(8'd3, 16'd1, 1'b1);
      chk("br_e0_ready", int'(CmdReady), 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("br_duty_%0d", k + 1), int'(DutyCycle), bexp[k]);
         chk($sformatf("br_ready_%0d", k + 1), int'(CmdReady), 1);
         chk($sformatf("br_done_%0d", k + 1), int'(Done), 0);
      end
      run_cmd(8'd0, 16'd1, 1'b0);
      chk("brx_e0_duty", int'(DutyCycle), 2);
      chk("brx_e0_ready", int'(CmdReady), 0);
      chk("brx_e0_busy", int'(Busy), 1);
      tick();
      chk("brx_e1_duty", int'(DutyCycle), 1);
      chk("brx_e1_done", int'(Done), 0);
      tick();
      chk("brx_e2_duty", int'(DutyCycle), 0);
      chk("brx_e2_done", int'(Done), 1);
      chk("brx_e2_busy", int'(Busy), 0);

      // Reset mid-ramp at duty 50
      run_cmd(8'd100, 16'd1, 1'b0);
      repeat (50) tick();
      chk("mr_pre_duty", int'(DutyCycle), 50);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("mr_duty", int'(DutyCycle), 0);
      chk("mr_busy", int'(Busy), 0);
      chk("mr_done", int'(Done), 0);
      chk("mr_ready", int'(CmdReady), 1);
      run_cmd(8'd2, 16'd1, 1'b0);
      tick();
      chk("mr_next_duty1", int'(DutyCycle), 1);
      tick();
      chk("mr_next_duty2", int'(DutyCycle), 2);
      chk("mr_next_done", int'(Done), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
